// File: rtl/rd_pattern_checker_if.sv
// rd_pattern_checker_if
// AXI4 read-address and read-data channel signals observed by the read
// pattern checker. The "master" modport drives the channels (the
// stimulus side). The "slave" modport only samples them, which is how the
// passive checker uses it.
//   ARADDR/ARLEN/ARVALID/ARREADY : read-address channel
//   RDATA/RRESP/RLAST/RVALID/RREADY : read-data channel
interface rd_pattern_checker_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARADDR, ARLEN, ARVALID, ARREADY,
    output RDATA, RRESP, RLAST, RVALID, RREADY
  );

  modport slave (
    input ARADDR, ARLEN, ARVALID, ARREADY,
    input RDATA, RRESP, RLAST, RVALID, RREADY
  );
endinterface

// File: rtl/rd_pattern_checker.sv
// rd_pattern_checker
// Passive checker on the AXI4 read-data path. Every accepted read address
// is queued. Each returned beat is matched against the pattern
// (beat_addr + 4k) ^ PATTERN_SEED in lane k. Burst length and RRESP are
// also checked. The block drives no AXI signal.
// Ports:
//   clk, reset (async, active high), clear (sync)
//   axi                 : read channels (slave modport, inputs only)
//   beat_count/burst_count                     : traffic counters (wrap)
//   data_err_count/resp_err_count/len_err_count : error counters (saturate)
//   first_err_addr/first_err_valid             : first data-mismatch address
//   fifo_ovf, error_detect                     : sticky flags
module rd_pattern_checker #(
  parameter int          DATA_W       = 512,
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          ERR_CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  rd_pattern_checker_if.slave      axi,
  output logic [31:0]              beat_count,
  output logic [31:0]              burst_count,
  output logic [ERR_CNT_W-1:0]     data_err_count,
  output logic [ERR_CNT_W-1:0]     resp_err_count,
  output logic [ERR_CNT_W-1:0]     len_err_count,
  output logic [ADDR_W-1:0]        first_err_addr,
  output logic                     first_err_valid,
  output logic                     fifo_ovf,
  output logic                     error_detect
);
  localparam int LANES = DATA_W / 32;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  // Builds the full expected beat word for a given beat address.
  function automatic logic [DATA_W-1:0] expected_word(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] w;
    logic [ADDR_W-1:0] a;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      a = addr + ADDR_W'(4 * k);
      w[32*k +: 32] = 32'(a) ^ PATTERN_SEED;
    end
    return w;
  endfunction

  // Increments an error counter, holding it at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  state_t                state_q, state_d;
  logic [7:0]            beat_idx_q, beat_idx_d;
  logic [ADDR_W-1:0]     beat_addr_q, beat_addr_d;
  logic [ADDR_W-1:0]     fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     fifo_addr_d [FIFO_DEPTH];
  logic [7:0]            fifo_len_q [FIFO_DEPTH];
  logic [7:0]            fifo_len_d [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic                  s1_valid_q, s1_valid_d, s1_cmp_q, s1_cmp_d;
  logic                  s1_resp_err_q, s1_resp_err_d, s1_len_err_q, s1_len_err_d;
  logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
  logic [DATA_W-1:0]     s1_rdata_q, s1_rdata_d, s1_exp_q, s1_exp_d;

  logic [31:0]           beat_count_q, beat_count_d, burst_count_q, burst_count_d;
  logic [ERR_CNT_W-1:0]  data_err_q, data_err_d, resp_err_q, resp_err_d, len_err_q, len_err_d;
  logic [ADDR_W-1:0]     first_err_addr_q, first_err_addr_d;
  logic                  first_err_valid_q, first_err_valid_d;
  logic                  fifo_ovf_q, fifo_ovf_d, error_detect_q, error_detect_d;

  logic                  r_hs, ar_hs, fifo_empty, fifo_full, at_len;
  logic                  tracked, orphan, pop, push, drop, len_err, mismatch, resp_hit;
  logic [ADDR_W-1:0]     head_addr, cur_addr;
  logic [7:0]            head_len, cur_idx;

  // Beat decode: where the current beat sits in its burst and what it triggers.
  always_comb begin
    r_hs       = axi.RVALID & axi.RREADY;
    ar_hs      = axi.ARVALID & axi.ARREADY;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    head_addr  = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
    head_len   = fifo_len_q[rd_ptr_q[PTR_W-1:0]];
    if (state_q == ACTIVE) begin
      cur_idx  = beat_idx_q + 8'd1;
      cur_addr = beat_addr_q + ADDR_W'(64);
    end else begin
      cur_idx  = 8'd0;
      cur_addr = head_addr;
    end
    at_len   = (cur_idx == head_len);
    // Occupancy is taken from the registered pointers, so an AR pushed in the
    // same cycle as a beat to an empty FIFO cannot claim that beat.
    tracked  = r_hs & ~fifo_empty;
    orphan   = r_hs & fifo_empty;
    pop      = tracked & (axi.RLAST | at_len);
    // RLAST and the ARLEN count must agree; any disagreement is a length error.
    len_err  = orphan | (tracked & (axi.RLAST ^ at_len));
    push     = ar_hs & (~fifo_full | pop);
    drop     = ar_hs & fifo_full & ~pop;
    mismatch = s1_cmp_q & (s1_rdata_q != s1_exp_q);
    resp_hit = s1_valid_q & s1_resp_err_q;
  end

  // Next-state for FIFO, tracking FSM, compare pipeline and statistics.
  always_comb begin
    state_d           = state_q;
    beat_idx_d        = beat_idx_q;
    beat_addr_d       = beat_addr_q;
    fifo_addr_d       = fifo_addr_q;
    fifo_len_d        = fifo_len_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    s1_valid_d        = r_hs;
    s1_cmp_d          = tracked;
    s1_resp_err_d     = (axi.RRESP != 2'b00);
    s1_len_err_d      = len_err;
    s1_addr_d         = s1_addr_q;
    s1_rdata_d        = s1_rdata_q;
    s1_exp_d          = s1_exp_q;
    beat_count_d      = beat_count_q;
    burst_count_d     = burst_count_q;
    data_err_d        = data_err_q;
    resp_err_d        = resp_err_q;
    len_err_d         = len_err_q;
    first_err_addr_d  = first_err_addr_q;
    first_err_valid_d = first_err_valid_q;
    fifo_ovf_d        = fifo_ovf_q | drop;
    error_detect_d    = error_detect_q | drop | mismatch | resp_hit | s1_len_err_q;

    if (push) begin
      fifo_addr_d[wr_ptr_q[PTR_W-1:0]] = axi.ARADDR;
      fifo_len_d[wr_ptr_q[PTR_W-1:0]]  = axi.ARLEN;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (r_hs) begin
      beat_count_d = beat_count_q + 32'd1;
      s1_addr_d    = cur_addr;
      s1_rdata_d   = axi.RDATA;
      s1_exp_d     = expected_word(cur_addr);
    end else begin
      beat_count_d = beat_count_q;
    end

    if (len_err) begin
      len_err_d = sat_inc(len_err_q);
    end else begin
      len_err_d = len_err_q;
    end

    if (tracked) begin
      if (pop) begin
        state_d       = IDLE;
        rd_ptr_d      = rd_ptr_q + (PTR_W+1)'(1);
        burst_count_d = burst_count_q + 32'd1;
      end else begin
        state_d     = ACTIVE;
        beat_idx_d  = cur_idx;
        beat_addr_d = cur_addr;
      end
    end else begin
      state_d = state_q;
    end

    if (mismatch) begin
      data_err_d = sat_inc(data_err_q);
      if (!first_err_valid_q) begin
        first_err_addr_d  = s1_addr_q;
        first_err_valid_d = 1'b1;
      end else begin
        first_err_addr_d  = first_err_addr_q;
      end
    end else begin
      data_err_d = data_err_q;
    end

    if (resp_hit) begin
      resp_err_d = sat_inc(resp_err_q);
    end else begin
      resp_err_d = resp_err_q;
    end

    // Clear wins over everything that happened this cycle.
    if (clear) begin
      state_d           = IDLE;
      beat_idx_d        = 8'd0;
      beat_addr_d       = '0;
      wr_ptr_d          = '0;
      rd_ptr_d          = '0;
      s1_valid_d        = 1'b0;
      s1_cmp_d          = 1'b0;
      s1_resp_err_d     = 1'b0;
      s1_len_err_d      = 1'b0;
      beat_count_d      = 32'd0;
      burst_count_d     = 32'd0;
      data_err_d        = '0;
      resp_err_d        = '0;
      len_err_d         = '0;
      first_err_addr_d  = '0;
      first_err_valid_d = 1'b0;
      fifo_ovf_d        = 1'b0;
      error_detect_d    = 1'b0;
    end else begin
      s1_valid_d = s1_valid_d;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      beat_idx_q        <= 8'd0;
      beat_addr_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_len_q[i]  <= 8'd0;
      end
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      s1_valid_q        <= 1'b0;
      s1_cmp_q          <= 1'b0;
      s1_resp_err_q     <= 1'b0;
      s1_len_err_q      <= 1'b0;
      s1_addr_q         <= '0;
      s1_rdata_q        <= '0;
      s1_exp_q          <= '0;
      beat_count_q      <= 32'd0;
      burst_count_q     <= 32'd0;
      data_err_q        <= '0;
      resp_err_q        <= '0;
      len_err_q         <= '0;
      first_err_addr_q  <= '0;
      first_err_valid_q <= 1'b0;
      fifo_ovf_q        <= 1'b0;
      error_detect_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      beat_idx_q        <= beat_idx_d;
      beat_addr_q       <= beat_addr_d;
      fifo_addr_q       <= fifo_addr_d;
      fifo_len_q        <= fifo_len_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      s1_valid_q        <= s1_valid_d;
      s1_cmp_q          <= s1_cmp_d;
      s1_resp_err_q     <= s1_resp_err_d;
      s1_len_err_q      <= s1_len_err_d;
      s1_addr_q         <= s1_addr_d;
      s1_rdata_q        <= s1_rdata_d;
      s1_exp_q          <= s1_exp_d;
      beat_count_q      <= beat_count_d;
      burst_count_q     <= burst_count_d;
      data_err_q        <= data_err_d;
      resp_err_q        <= resp_err_d;
      len_err_q         <= len_err_d;
      first_err_addr_q  <= first_err_addr_d;
      first_err_valid_q <= first_err_valid_d;
      fifo_ovf_q        <= fifo_ovf_d;
      error_detect_q    <= error_detect_d;
    end
  end

  assign beat_count      = beat_count_q;
  assign burst_count     = burst_count_q;
  assign data_err_count  = data_err_q;
  assign resp_err_count  = resp_err_q;
  assign len_err_count   = len_err_q;
  assign first_err_addr  = first_err_addr_q;
  assign first_err_valid = first_err_valid_q;
  assign fifo_ovf        = fifo_ovf_q;
  assign error_detect    = error_detect_q;
endmodule

// File: tb/tb_rd_pattern_checker.sv
module tb_rd_pattern_checker;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [31:0] beat_count, burst_count;
  logic [15:0] data_err_count, resp_err_count, len_err_count;
  logic [31:0] first_err_addr;
  logic        first_err_valid, fifo_ovf, error_detect;

  rd_pattern_checker_if #(.DATA_W(512), .ADDR_W(32)) bus ();

  rd_pattern_checker dut (
    .clk(clk), .reset(reset), .clear(clear), .axi(bus),
    .beat_count(beat_count), .burst_count(burst_count),
    .data_err_count(data_err_count), .resp_err_count(resp_err_count),
    .len_err_count(len_err_count), .first_err_addr(first_err_addr),
    .first_err_valid(first_err_valid), .fifo_ovf(fifo_ovf),
    .error_detect(error_detect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit data_err; bit resp_err; } sb_t;
  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_data = 0;
  int  exp_resp = 0;

  function automatic logic [511:0] pattern(input logic [31:0] a);
    logic [511:0] p;
    for (int k = 0; k < 16; k++) p[32*k +: 32] = (a + 32'(4 * k)) ^ SEED;
    return p;
  endfunction

  // Pops every expected beat result and folds it into the running totals.
  task automatic drain_sb();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      exp_data += int'(e.data_err);
      exp_resp += int'(e.resp_err);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sb_q.delete();
    exp_data = 0;
    exp_resp = 0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len);
    bus.ARADDR = addr; bus.ARLEN = len; bus.ARVALID = 1'b1; bus.ARREADY = 1'b1;
    @(negedge clk);
    bus.ARVALID = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] addr, input logic last, input int bad_lane,
                           input logic [1:0] resp, input bit tracked);
    logic [511:0] d;
    sb_t e;
    d = pattern(addr);
    if (bad_lane >= 0) d[32*bad_lane +: 32] = ~d[32*bad_lane +: 32];
    bus.RDATA = d; bus.RRESP = resp; bus.RLAST = last; bus.RVALID = 1'b1; bus.RREADY = 1'b1;
    e.data_err = (bad_lane >= 0) && tracked;
    e.resp_err = (resp != 2'b00);
    sb_q.push_back(e);
    @(negedge clk);
    bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
  endtask

  task automatic test_reset();
    checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL reset_beat: got %0d want 0", beat_count); end
    checks++; if (burst_count !== 32'd0) begin errors++; $display("FAIL reset_burst: got %0d want 0", burst_count); end
    checks++; if (data_err_count !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data_err_count); end
    checks++; if (resp_err_count !== 16'd0) begin errors++; $display("FAIL reset_resp: got %0d want 0", resp_err_count); end
    checks++; if (len_err_count !== 16'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", len_err_count); end
    checks++; if (first_err_valid !== 1'b0) begin errors++; $display("FAIL reset_fev: got %b want 0", first_err_valid); end
    checks++; if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", fifo_ovf); end
    checks++; if (error_detect !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", error_detect); end
  endtask

  task automatic test_good_burst();
    do_clear();
    send_ar(32'h0000_1000, 8'd3);
    for (int i = 0; i < 4; i++) send_beat(32'h0000_1000 + 32'(64 * i), (i == 3), -1, 2'b00, 1'b1);
    repeat (3) @(negedge clk);
    drain_sb();
    checks++; if (beat_count !== 32'd4) begin errors++; $display("FAIL good_beats: got %0d want 4", beat_count); end
    checks++; if (burst_count !== 32'd1) begin errors++; $display("FAIL good_bursts: got %0d want 1", burst_count); end
    checks++; if (data_err_count !== 16'(exp_data)) begin errors++; $display("FAIL good_data: got %0d want %0d", data_err_count, exp_data); end
    checks++; if (len_err_count !== 16'd0) begin errors++; $display("FAIL good_len: got %0d want 0", len_err_count); end
    checks++; if (error_detect !== 1'b0) begin errors++; $display("FAIL good_err: got %b want 0", error_detect); end
  endtask

  task automatic test_data_err();
    do_clear();
    send_ar(32'h0000_1000, 8'd3);
    send_beat(32'h0000_1000, 1'b0, -1, 2'b00, 1'b1);
    send_beat(32'h0000_1040, 1'b0, -1, 2'b00, 1'b1);
    send_beat(32'h0000_1080, 1'b0, 5, 2'b00, 1'b1);
    checks++; if (data_err_count !== 16'd0) begin errors++; $display("FAIL derr_early: got %0d want 0", data_err_count); end
    send_beat(32'h0000_10C0, 1'b1, -1, 2'b00, 1'b1);
    checks++; if (data_err_count !== 16'd1) begin errors++; $display("FAIL derr_lat2: got %0d want 1", data_err_count); end
    checks++; if (first_err_addr !== 32'h0000_1080) begin errors++; $display("FAIL derr_addr: got %h want 00001080", first_err_addr); end
    checks++; if (first_err_valid !== 1'b1) begin errors++; $display("FAIL derr_fev: got %b want 1", first_err_valid); end
    checks++; if (error_detect !== 1'b1) begin errors++; $display("FAIL derr_det: got %b want 1", error_detect); end
    repeat (3) @(negedge clk);
    drain_sb();
    checks++; if (data_err_count !== 16'(exp_data)) begin errors++; $display("FAIL derr_total: got %0d want %0d", data_err_count, exp_data); end
    checks++; if (burst_count !== 32'd1) begin errors++; $display("FAIL derr_burst: got %0d want 1", burst_count); end
  endtask

  task automatic test_len_err();
    do_clear();
    send_ar(32'h0000_2000, 8'd7);
    send_ar(32'h0000_3000, 8'd1);
    for (int i = 0; i < 6; i++) send_beat(32'h0000_2000 + 32'(64 * i), (i == 5), -1, 2'b00, 1'b1);
    send_beat(32'h0000_3000, 1'b0, -1, 2'b00, 1'b1);
    send_beat(32'h0000_3040, 1'b1, -1, 2'b00, 1'b1);
    repeat (3) @(negedge clk);
    drain_sb();
    checks++; if (len_err_count !== 16'd1) begin errors++; $display("FAIL len_cnt: got %0d want 1", len_err_count); end
    checks++; if (burst_count !== 32'd2) begin errors++; $display("FAIL len_bursts: got %0d want 2", burst_count); end
    checks++; if (data_err_count !== 16'(exp_data)) begin errors++; $display("FAIL len_data: got %0d want %0d", data_err_count, exp_data); end
    checks++; if (beat_count !== 32'd8) begin errors++; $display("FAIL len_beats: got %0d want 8", beat_count); end
    checks++; if (error_detect !== 1'b1) begin errors++; $display("FAIL len_det: got %b want 1", error_detect); end
  endtask

  task automatic test_fifo_ovf();
    do_clear();
    for (int i = 0; i < 4; i++) send_ar(32'h0000_4000 + 32'(256 * i), 8'd0);
    checks++; if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", fifo_ovf); end
    send_ar(32'h0000_4400, 8'd0);
    checks++; if (fifo_ovf !== 1'b1) begin errors++; $display("FAIL ovf_fifth: got %b want 1", fifo_ovf); end
    checks++; if (error_detect !== 1'b1) begin errors++; $display("FAIL ovf_det: got %b want 1", error_detect); end
    // Sixth AR shares the cycle with the beat that closes the head burst.
    bus.ARADDR = 32'h0000_4500; bus.ARLEN = 8'd0; bus.ARVALID = 1'b1; bus.ARREADY = 1'b1;
    send_beat(32'h0000_4000, 1'b1, -1, 2'b00, 1'b1);
    bus.ARVALID = 1'b0;
    send_beat(32'h0000_4100, 1'b1, -1, 2'b00, 1'b1);
    send_beat(32'h0000_4200, 1'b1, -1, 2'b00, 1'b1);
    send_beat(32'h0000_4300, 1'b1, -1, 2'b00, 1'b1);
    send_beat(32'h0000_4500, 1'b1, -1, 2'b00, 1'b1);
    repeat (3) @(negedge clk);
    drain_sb();
    checks++; if (len_err_count !== 16'd0) begin errors++; $display("FAIL ovf_len: got %0d want 0", len_err_count); end
    checks++; if (data_err_count !== 16'(exp_data)) begin errors++; $display("FAIL ovf_data: got %0d want %0d", data_err_count, exp_data); end
    checks++; if (burst_count !== 32'd5) begin errors++; $display("FAIL ovf_bursts: got %0d want 5", burst_count); end
  endtask

  task automatic test_resp_wrap();
    do_clear();
    send_ar(32'h0000_5000, 8'd0);
    send_beat(32'h0000_5000, 1'b1, -1, 2'b10, 1'b1);
    send_ar(32'hFFFF_FFC0, 8'd1);
    send_beat(32'hFFFF_FFC0, 1'b0, -1, 2'b00, 1'b1);
    send_beat(32'h0000_0000, 1'b1, -1, 2'b00, 1'b1);
    repeat (3) @(negedge clk);
    drain_sb();
    checks++; if (resp_err_count !== 16'(exp_resp)) begin errors++; $display("FAIL resp_cnt: got %0d want %0d", resp_err_count, exp_resp); end
    checks++; if (resp_err_count !== 16'd1) begin errors++; $display("FAIL resp_one: got %0d want 1", resp_err_count); end
    checks++; if (data_err_count !== 16'(exp_data)) begin errors++; $display("FAIL wrap_data: got %0d want %0d", data_err_count, exp_data); end
    checks++; if (len_err_count !== 16'd0) begin errors++; $display("FAIL wrap_len: got %0d want 0", len_err_count); end
    checks++; if (burst_count !== 32'd2) begin errors++; $display("FAIL wrap_bursts: got %0d want 2", burst_count); end
  endtask

  task automatic test_reset_mid_burst();
    do_clear();
    send_ar(32'h0000_6000, 8'd3);
    send_beat(32'h0000_6000, 1'b0, -1, 2'b00, 1'b1);
    send_beat(32'h0000_6040, 1'b0, -1, 2'b00, 1'b1);
    reset = 1'b1;
    #1;
    checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL rst_beat: got %0d want 0", beat_count); end
    checks++; if (burst_count !== 32'd0 || len_err_count !== 16'd0) begin errors++; $display("FAIL rst_cnts: got %0d/%0d want 0/0", burst_count, len_err_count); end
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete(); exp_data = 0; exp_resp = 0;
    send_beat(32'h0000_6080, 1'b0, -1, 2'b00, 1'b0);
    send_beat(32'h0000_60C0, 1'b1, -1, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    drain_sb();
    checks++; if (len_err_count !== 16'd2) begin errors++; $display("FAIL rst_len: got %0d want 2", len_err_count); end
    checks++; if (burst_count !== 32'd0) begin errors++; $display("FAIL rst_bursts: got %0d want 0", burst_count); end
    checks++; if (data_err_count !== 16'(exp_data)) begin errors++; $display("FAIL rst_data: got %0d want %0d", data_err_count, exp_data); end
    checks++; if (beat_count !== 32'd2) begin errors++; $display("FAIL rst_beats2: got %0d want 2", beat_count); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0; bus.ARREADY = 1'b0;
    bus.RDATA = '0; bus.RRESP = '0; bus.RLAST = 1'b0; bus.RVALID = 1'b0; bus.RREADY = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_good_burst();
    test_data_err();
    test_len_err();
    test_fifo_ovf();
    test_resp_wrap();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
